window_gen_3x3: RTL and testbench

- Streaming 3x3 neighbourhood generator that is the producer side of the 9-tap kernel interface (in0..in8) used by the dehazing filter blocks.
- Accepts a raster-order pixel stream, one pixel per handshake, and buffers two image lines.
- Emits each fully interior 3x3 window as nine parallel pixels with a valid/ready handshake, ready for direct connection to the weighted-sum kernels.

---
 rtl/window_gen_3x3.sv | 165 ++++++++++++++++
 tb/tb_window_gen_3x3.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_gen_3x3.sv
// window_gen_3x3
//   Streaming 3x3 neighbourhood generator. It takes a raster-order pixel
//   stream, keeps the two previous lines in line buffers, and emits every
//   fully interior 3x3 window as nine parallel pixels (win0 top-left,
//   win4 centre, win8 bottom-right) behind a single output register.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    pixel handshake, in_ready = !win_valid || win_ready
//   in_pixel             raster-order pixel, row 0 col 0 first
//   in_sof               (WINDOW_GEN_FRAME_SYNC_EN only) start-of-frame flag
//   win_valid/win_ready  window handshake
//   win0..win8           row-major 3x3 window
//   win_last             marks the final window of a frame
//   frame_done           one-cycle pulse after the last pixel of a frame
//
// Build option
//   WINDOW_GEN_FRAME_SYNC_EN  adds in_sof; an accepted pixel with in_sof=1
//                             restarts the frame at row 0 col 0.
//
// state  | meaning
// FILL   | rows 0..1 of the frame, line buffers priming, no windows
// STREAM | row 2 onward, a window per accepted pixel with col >= 2

module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
`ifdef WINDOW_GEN_FRAME_SYNC_EN
  input  logic              in_sof,
`endif
  output logic              win_valid,
  input  logic              win_ready,
  output logic [DATA_W-1:0] win0,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic [DATA_W-1:0] win5,
  output logic [DATA_W-1:0] win6,
  output logic [DATA_W-1:0] win7,
  output logic [DATA_W-1:0] win8,
  output logic              win_last,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic {FILL, STREAM} state_t;

  state_t          state, state_e;
  logic [CW-1:0]   col, col_e;
  logic [RW-1:0]   row, row_e;
  logic            accept, sof_hit, col_end, row_end, emit;

  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  // Only the two most recent columns are stored; the third (rightmost)
  // column of each window comes straight from the line buffers and input.
  logic [DATA_W-1:0] top_a, top_b, mid_a, mid_b, bot_a, bot_b;

  assign in_ready = !win_valid || win_ready;

  always_comb begin
    accept  = in_valid && in_ready;
`ifdef WINDOW_GEN_FRAME_SYNC_EN
    sof_hit = in_sof;
`else
    sof_hit = 1'b0;
`endif
    // Effective position/state of the pixel being offered: a start-of-frame
    // pixel is treated as (0,0) in FILL regardless of the counters.
    col_e   = sof_hit ? '0   : col;
    row_e   = sof_hit ? '0   : row;
    state_e = sof_hit ? FILL : state;
    col_end = (col_e == CW'(IMG_WIDTH - 1));
    row_end = (row_e == RW'(IMG_HEIGHT - 1));
    emit    = accept && (state_e == STREAM) && (col_e >= CW'(2));
    lb0_rd  = lb0[col_e];
    lb1_rd  = lb1[col_e];
  end

  // Line buffers hold no reset; stale contents are overwritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_e] <= lb0_rd;
      lb0[col_e] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      col        <= '0;
      row        <= '0;
      top_a      <= '0;
      top_b      <= '0;
      mid_a      <= '0;
      mid_b      <= '0;
      bot_a      <= '0;
      bot_b      <= '0;
      win_valid  <= 1'b0;
      win0       <= '0;
      win1       <= '0;
      win2       <= '0;
      win3       <= '0;
      win4       <= '0;
      win5       <= '0;
      win6       <= '0;
      win7       <= '0;
      win8       <= '0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row_e + RW'(1);
        end else begin
          col <= col_e + CW'(1);
          row <= row_e;
        end
        case (state_e)
          FILL:    state <= (row_e == RW'(2) && col_e == '0) ? STREAM : FILL;
          STREAM:  state <= (row_end && col_end) ? FILL : STREAM;
          default: state <= FILL;
        endcase
        top_a      <= top_b;
        top_b      <= lb1_rd;
        mid_a      <= mid_b;
        mid_b      <= lb0_rd;
        bot_a      <= bot_b;
        bot_b      <= in_pixel;
        frame_done <= row_end && col_end;
      end

      if (emit) begin
        win_valid <= 1'b1;
        win0      <= top_a;
        win1      <= top_b;
        win2      <= lb1_rd;
        win3      <= mid_a;
        win4      <= mid_b;
        win5      <= lb0_rd;
        win6      <= bot_a;
        win7      <= bot_b;
        win8      <= in_pixel;
        win_last  <= row_end && col_end;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
module tb_window_gen_3x3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, win_ready;
  logic [7:0]  in_pixel;
  logic        win_valid, win_last, frame_done;
  logic [7:0]  w0, w1, w2, w3, w4, w5, w6, w7, w8;
`ifdef WINDOW_GEN_FRAME_SYNC_EN
  logic        in_sof = 1'b0;
  logic        in_sof3 = 1'b0;
`endif

  logic        in_valid3, in_ready3, win_ready3;
  logic [7:0]  in_pixel3;
  logic        win_valid3, win_last3, frame_done3;
  logic [7:0]  v0, v1, v2, v3, v4, v5, v6, v7, v8;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int fd3_cnt = 0;
  int win3_cnt = 0;

  logic [71:0] q_w[$];
  bit          q_l[$];
  logic [71:0] ref_w[4];

  wire [71:0] wv  = {w0, w1, w2, w3, w4, w5, w6, w7, w8};
  wire [71:0] wv3 = {v0, v1, v2, v3, v4, v5, v6, v7, v8};

  always #5 clk = ~clk;

  window_gen_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel),
`ifdef WINDOW_GEN_FRAME_SYNC_EN
    .in_sof(in_sof),
`endif
    .win_valid(win_valid), .win_ready(win_ready),
    .win0(w0), .win1(w1), .win2(w2), .win3(w3), .win4(w4),
    .win5(w5), .win6(w6), .win7(w7), .win8(w8),
    .win_last(win_last), .frame_done(frame_done)
  );

  window_gen_3x3 #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_pixel(in_pixel3),
`ifdef WINDOW_GEN_FRAME_SYNC_EN
    .in_sof(in_sof3),
`endif
    .win_valid(win_valid3), .win_ready(win_ready3),
    .win0(v0), .win1(v1), .win2(v2), .win3(v3), .win4(v4),
    .win5(v5), .win6(v6), .win7(v7), .win8(v8),
    .win_last(win_last3), .frame_done(frame_done3)
  );

  // Handshakes are sampled mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (win_valid && win_ready) begin
      q_w.push_back(wv);
      q_l.push_back(win_last);
    end
    if (frame_done)  fd_cnt++;
    if (frame_done3) fd3_cnt++;
    if (win_valid3 && win_ready3) win3_cnt++;
  end

  // 4-wide image with pixel = 4r+c: window with top-left value tl.
  function automatic logic [71:0] expw(input int tl);
    logic [7:0] t;
    t = 8'(tl);
    return {t, t + 8'd1, t + 8'd2, t + 8'd4, t + 8'd5, t + 8'd6,
            t + 8'd8, t + 8'd9, t + 8'd10};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer pixels first..last (value = index); rnd adds bubbles and random win_ready.
  task automatic send(input int first, input int last, input bit rnd);
    for (int k = first; k <= last; k++) begin
      bit acc;
      int guard;
      acc = 1'b0;
      guard = 0;
      in_pixel = 8'(k);
      while (!acc && guard < 200) begin
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rnd) win_ready = 1'($urandom_range(0, 1));
        #3;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        total++;
        bad++;
        $error("FAIL send_timeout: pixel=%0d not accepted, required accept", k);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int nframes);
    chk({tag, "_count"}, 72'(q_w.size()), 72'(4 * nframes));
    for (int i = 0; i < q_w.size() && i < 4 * nframes; i++) begin
      chk($sformatf("%s_win%0d", tag, i), q_w[i], ref_w[i % 4]);
      chk($sformatf("%s_last%0d", tag, i), 72'(q_l[i]), 72'((i % 4) == 3));
    end
  endtask

  initial begin
    int fd0;
    ref_w[0] = expw(0);
    ref_w[1] = expw(1);
    ref_w[2] = expw(4);
    ref_w[3] = expw(5);

    rst_n = 1'b0; in_valid = 1'b0; in_pixel = '0; win_ready = 1'b1;
    in_valid3 = 1'b0; in_pixel3 = '0; win_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 72'(in_ready), 72'd1);
    chk("rst_win_valid", 72'(win_valid), 72'd0);
    chk("rst_window", wv, 72'd0);
    chk("rst_win_last", 72'(win_last), 72'd0);
    chk("rst_frame_done", 72'(frame_done), 72'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Gap-free frame with latency checks.
    fd0 = fd_cnt;
    send(0, 9, 0);
    chk("t1_no_win_before_p10", 72'(win_valid), 72'd0);
    send(10, 10, 0);
    chk("t1_valid_after_p10", 72'(win_valid), 72'd1);
    chk("t1_first_window", wv, expw(0));
    send(11, 14, 0);
    chk("t1_no_fd_early", 72'(frame_done), 72'd0);
    send(15, 15, 0);
    chk("t1_last_window", wv, expw(5));
    chk("t1_win_last", 72'(win_last), 72'd1);
    chk("t1_frame_done", 72'(frame_done), 72'd1);
    @(posedge clk);
    #1;
    chk("t1_fd_pulse_end", 72'(frame_done), 72'd0);
    chk("t1_valid_clear", 72'(win_valid), 72'd0);
    check_frame("t1", 1);
    chk("t1_fd_count", 72'(fd_cnt - fd0), 72'd1);

    // Backpressure at the second window.
    q_w.delete(); q_l.delete();
    fd0 = fd_cnt;
    send(0, 11, 0);
    win_ready = 1'b0;
    in_pixel = 8'd12;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t2_hold_valid%0d", i), 72'(win_valid), 72'd1);
      chk($sformatf("t2_hold_window%0d", i), wv, expw(1));
      chk($sformatf("t2_in_ready_low%0d", i), 72'(in_ready), 72'd0);
    end
    win_ready = 1'b1;
    send(12, 15, 0);
    repeat (2) @(posedge clk);
    #1;
    check_frame("t2", 1);
    chk("t2_fd_count", 72'(fd_cnt - fd0), 72'd1);

    // Two back-to-back frames with random bubbles and backpressure.
    q_w.delete(); q_l.delete();
    fd0 = fd_cnt;
    send(0, 15, 1);
    send(0, 15, 1);
    win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_frame("t3", 2);
    chk("t3_fd_count", 72'(fd_cnt - fd0), 72'd2);

    // Reset mid-frame after pixel 9, then restart.
    q_w.delete(); q_l.delete();
    send(0, 9, 0);
    fd0 = fd_cnt;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", 72'(win_valid), 72'd0);
    chk("t4_rst_in_ready", 72'(in_ready), 72'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 9, 0);
    chk("t4_no_stale_window", 72'(q_w.size()), 72'd0);
    send(10, 15, 0);
    repeat (2) @(posedge clk);
    #1;
    check_frame("t4", 1);
    chk("t4_fd_count", 72'(fd_cnt - fd0), 72'd1);

`ifdef WINDOW_GEN_FRAME_SYNC_EN
    // Partial frame, then a new frame marked by in_sof.
    q_w.delete(); q_l.delete();
    fd0 = fd_cnt;
    send(0, 6, 0);
    in_sof = 1'b1;
    send(0, 0, 0);
    in_sof = 1'b0;
    send(1, 9, 0);
    chk("t5_no_early_window", 72'(q_w.size()), 72'd0);
    send(10, 15, 0);
    repeat (2) @(posedge clk);
    #1;
    check_frame("t5", 1);
    chk("t5_fd_count", 72'(fd_cnt - fd0), 72'd1);
`endif

    // Minimum 3x3 image: exactly one window.
    for (int k = 0; k < 9; k++) begin
      in_pixel3 = 8'(k);
      in_valid3 = 1'b1;
      @(posedge clk);
      #1;
      if (k == 7) chk("t6_no_win_before_last", 72'(win_valid3), 72'd0);
    end
    in_valid3 = 1'b0;
    chk("t6_valid", 72'(win_valid3), 72'd1);
    chk("t6_window", wv3, {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
    chk("t6_win_last", 72'(win_last3), 72'd1);
    chk("t6_frame_done", 72'(frame_done3), 72'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_valid_clear", 72'(win_valid3), 72'd0);
    chk("t6_win_count", 72'(win3_cnt), 72'd1);
    chk("t6_fd_count", 72'(fd3_cnt), 72'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
